ahb_coord_in: RTL and testbench
===============================

// Module: ahb_coord_in
// PURPOSE
//  AHB-Lite slave that accepts (x,y) coordinate samples from a hardware producer.
//  Producer side uses a valid/ready handshake; samples are buffered in a small FIFO.
//  M0 software pops, peeks and monitors samples over AHB.
//  Input counterpart of the coordinate output peripheral; sits on the same AHB-Lite bus.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2. CW = $clog2(DEPTH)+1 (count width)
// PORTS
//  HCLK       in   1   bus clock; all state on posedge
//  HRESET     in   1   synchronous, active-high reset
//  HADDR      in   32  only HADDR[3:2] decoded
//  HWDATA     in   32  write data (data phase)
//  HSIZE      in   3   ignored; word/half-word accesses both honoured
//  HTRANS     in   2   transfer type; 2'b00 = no transfer
//  HWRITE     in   1   1 = write
//  HREADY     in   1   bus ready
//  HSEL       in   1   slave select
//  HRDATA     out  32  read data (data phase)
//  HREADYOUT  out  1   slave ready
//  x_in       in   9   producer x coordinate
//  y_in       in   9   producer y coordinate
//  DataValid  in   1   producer has a sample on x_in/y_in
//  DataReady  out  1   FIFO can accept; push when DataValid && DataReady
// BEHAVIOUR
//  Address phase: if HREADY && HSEL && HTRANS!=0, register rd_en=!HWRITE, wr_en=HWRITE,
//   word_addr=HADDR[3:2]. If HREADY && !(select), clear all three. If !HREADY, hold all three.
//  Address map (word_addr):
//   0 DATA   rd: {7'd0,y,7'd0,x} of head entry; pops it.  wr: ignored
//   1 STATUS rd: [CW+7:8]=count, [3]=Underflow, [2]=Stalled, [1]=Full, [0]=NotEmpty
//   2 CTRL   wr: HWDATA[0]=flush FIFO, HWDATA[1]=clear sticky flags.  rd: 0
//   3 PEEK   rd: same format as DATA, no pop; 0 if empty.  wr: ignored
//  HRDATA = 0 whenever rd_en==0.
//  DataReady = (count != DEPTH), combinational from registered count.
//  Push: DataValid && DataReady -> entry written at tail; tail wraps modulo DEPTH.
//  Pop: rd_en && word_addr==0 && count!=0 && HREADYOUT -> head advances, wraps modulo DEPTH.
//  Push+pop in the same cycle: count unchanged, both pointers advance.
//  Empty DATA read: returns 0, no pop, sets Underflow. Exception: under AHB_IN_WAIT_EN, see CONFIGURATION.
//  Stalled (sticky): set in any cycle with DataValid && !DataReady.
//  Sticky flags: set and clear in the same cycle -> set wins.
//  Flush: count/head/tail <- 0. Flush with a same-cycle push -> flush wins, sample dropped.
//   Flush with a same-cycle pop is impossible: a data phase carries only one access.
//  Reset: count/pointers/flags/addr regs 0. Gives HRDATA=0, HREADYOUT=1, DataReady=1.
//   Reset overrides any pending wait. FIFO storage is not reset.
// CONFIGURATION
//  AHB_IN_WAIT_EN undefined: HREADYOUT tied 1; zero wait states; empty DATA read -> 0 + Underflow.
//  AHB_IN_WAIT_EN defined: HREADYOUT = !(rd_en && word_addr==0 && count==0).
//   An empty DATA read stalls the bus until a push lands.
//   Push accepted in cycle N -> HREADYOUT=1 in cycle N+1, with the sample on HRDATA; popped that cycle.
//   Underflow is never set by a stalled read.
//   A push in cycle N+1 alongside the pop is accepted normally.
// TESTING
//  1. Reset, read STATUS -> 0; DataReady=1, HREADYOUT=1.
//  2. Push (x=9'h1A5,y=9'h0C3) then read DATA -> 32'h00C3_01A5; STATUS count then reads 0.
//  3. Push 4 samples, hold DataValid -> DataReady=0; STATUS = count 4, Full, Stalled, NotEmpty.
//     Next push is accepted only after one DATA pop.
//  4. Empty DATA read (macro off) -> 0, Underflow=1.
//     CTRL write 2'b10 -> flags clear. CTRL write 2'b01 with 3 queued -> count 0.
//  5. Push and DATA pop in the same cycle at count=2 -> count stays 2; order preserved across pointer wrap.
//  6. Macro on: empty DATA read, push 5 cycles later -> HREADYOUT low 5 cycles, then data returned.
//     Reset asserted mid-stall -> HREADYOUT=1 next cycle.

Source files
------------

// File: rtl/ahb_coord_in.sv
// AHB-Lite slave buffering (x,y) samples from a valid/ready producer in a small FIFO.
// Optional macro AHB_IN_WAIT_EN: an empty DATA read inserts wait states until a sample arrives.
module ahb_coord_in #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic        HSEL,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    input  logic [8:0]  x_in,
    input  logic [8:0]  y_in,
    input  logic        DataValid,
    output logic        DataReady
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic [1:0]    addr_q, addr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic          underflow_q, underflow_d;
    logic          stalled_q, stalled_d;
    logic [17:0]   mem [DEPTH];

    logic        sel, push, pop, data_rd, ctrl_wr, flush, clr_flags, underflow_set;
    logic [31:0] head_word, status_word;
    logic        unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:2]};

`ifdef AHB_IN_WAIT_EN
    assign HREADYOUT = !(rd_en_q && addr_q == 2'd0 && count_q == '0);
`else
    assign HREADYOUT = 1'b1;
`endif

    assign DataReady = (count_q != CW'(DEPTH));

    always_comb begin
        sel           = HREADY && HSEL && (HTRANS != 2'b00);
        push          = DataValid && DataReady;
        data_rd       = rd_en_q && (addr_q == 2'd0);
        pop           = data_rd && (count_q != '0) && HREADYOUT;
        ctrl_wr       = wr_en_q && (addr_q == 2'd2);
        flush         = ctrl_wr && HWDATA[0];
        clr_flags     = ctrl_wr && HWDATA[1];
`ifdef AHB_IN_WAIT_EN
        underflow_set = 1'b0;
`else
        underflow_set = data_rd && (count_q == '0);
`endif

        rd_en_d = rd_en_q;
        wr_en_d = wr_en_q;
        addr_d  = addr_q;
        if (HREADY) begin
            rd_en_d = sel && !HWRITE;
            wr_en_d = sel && HWRITE;
            addr_d  = sel ? HADDR[3:2] : 2'd0;
        end

        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            // Flush beats a same-cycle push; the sample is dropped.
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (push) tail_d = tail_q + 1'b1;
            if (pop)  head_d = head_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end

        // Set wins over a same-cycle clear.
        underflow_d = underflow_q;
        stalled_d   = stalled_q;
        if (clr_flags) begin
            underflow_d = 1'b0;
            stalled_d   = 1'b0;
        end
        if (underflow_set)           underflow_d = 1'b1;
        if (DataValid && !DataReady) stalled_d   = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= 2'd0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            underflow_q <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            underflow_q <= underflow_d;
            stalled_q   <= stalled_d;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push && !flush) mem[tail_q] <= {y_in, x_in};
    end

    always_comb begin
        head_word = {7'd0, mem[head_q][17:9], 7'd0, mem[head_q][8:0]};
        status_word = '0;
        status_word[CW+7:8] = count_q;
        status_word[3:0] = {underflow_q, stalled_q, ~DataReady, count_q != '0};

        HRDATA = 32'd0;
        if (rd_en_q) begin
            unique case (addr_q)
                2'd0:    HRDATA = (count_q != '0) ? head_word : 32'd0;
                2'd1:    HRDATA = status_word;
                2'd3:    HRDATA = (count_q != '0) ? head_word : 32'd0;
                default: HRDATA = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_coord_in.sv
// Directed self-checking bench for ahb_coord_in; the wait-state scenario runs when
// AHB_IN_WAIT_EN is defined, the underflow scenario when it is not.
module tb_ahb_coord_in;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] HADDR = '0;
    logic [31:0] HWDATA = '0;
    logic [2:0]  HSIZE = 3'b010;
    logic [1:0]  HTRANS = '0;
    logic        HWRITE = 1'b0;
    logic        HREADY;
    logic        HSEL = 1'b0;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [8:0]  x_in = '0;
    logic [8:0]  y_in = '0;
    logic        DataValid = 1'b0;
    logic        DataReady;

    int vectors = 0;
    int miscompares = 0;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_coord_in #(.DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .x_in(x_in), .y_in(y_in), .DataValid(DataValid),
        .DataReady(DataReady)
    );

    task automatic ahb_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a, 2'b00};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        for (int i = 0; i < 50 && !HREADYOUT; i++) @(negedge HCLK);
        d = HRDATA;
    endtask

    task automatic ahb_wr(input logic [1:0] a, input logic [31:0] w);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a, 2'b00};
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = w;
    endtask

    task automatic push(input logic [8:0] x, input logic [8:0] y);
        @(negedge HCLK);
        x_in = x; y_in = y; DataValid = 1'b1;
        @(negedge HCLK);
        DataValid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        HRESET = 1'b1;
        repeat (2) @(negedge HCLK);
        vectors++;
        if (HRDATA !== 32'd0) begin
            $display("FAIL reset_hrdata got %h want %h", HRDATA, 32'd0); miscompares++;
        end
        vectors++;
        if (HREADYOUT !== 1'b1) begin
            $display("FAIL reset_hreadyout got %b want 1", HREADYOUT); miscompares++;
        end
        vectors++;
        if (DataReady !== 1'b1) begin
            $display("FAIL reset_dataready got %b want 1", DataReady); miscompares++;
        end
        HRESET = 1'b0;
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL reset_status got %h want %h", d, 32'd0); miscompares++;
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        push(9'h1A5, 9'h0C3);
        ahb_rd(2'd3, d);
        vectors++;
        if (d !== 32'h00C3_01A5) begin
            $display("FAIL peek got %h want %h", d, 32'h00C3_01A5); miscompares++;
        end
        ahb_rd(2'd0, d);
        vectors++;
        if (d !== 32'h00C3_01A5) begin
            $display("FAIL single_data got %h want %h", d, 32'h00C3_01A5); miscompares++;
        end
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL single_status got %h want %h", d, 32'd0); miscompares++;
        end
    endtask

    task automatic test_full_stall();
        logic [31:0] d;
        logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            x_in = 9'(i + 1); y_in = 9'(i + 16); DataValid = 1'b1;
        end
        @(negedge HCLK);
        vectors++;
        if (DataReady !== 1'b0) begin
            $display("FAIL full_dataready got %b want 0", DataReady); miscompares++;
        end
        x_in = 9'd5; y_in = 9'h020;
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'h0000_0407) begin
            $display("FAIL full_status got %h want %h", d, 32'h0000_0407); miscompares++;
        end
        ahb_rd(2'd0, d);
        vectors++;
        if (d !== 32'h0010_0001) begin
            $display("FAIL full_pop got %h want %h", d, 32'h0010_0001); miscompares++;
        end
        vectors++;
        if (DataReady !== 1'b0) begin
            $display("FAIL before_pop_ready got %b want 0", DataReady); miscompares++;
        end
        @(negedge HCLK);
        vectors++;
        if (DataReady !== 1'b1) begin
            $display("FAIL after_pop_ready got %b want 1", DataReady); miscompares++;
        end
        @(negedge HCLK);
        DataValid = 1'b0;
        vectors++;
        if (DataReady !== 1'b0) begin
            $display("FAIL refill_ready got %b want 0", DataReady); miscompares++;
        end
        for (int i = 1; i < 5; i++) begin
            exp = (i == 4) ? 32'h0020_0005 : {7'd0, 9'(i + 16), 7'd0, 9'(i + 1)};
            ahb_rd(2'd0, d);
            vectors++;
            if (d !== exp) begin
                $display("FAIL drain_%0d got %h want %h", i, d, exp); miscompares++;
            end
        end
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'h0000_0004) begin
            $display("FAIL drained_status got %h want %h", d, 32'h0000_0004); miscompares++;
        end
    endtask

    task automatic test_underflow_ctrl();
        logic [31:0] d;
`ifndef AHB_IN_WAIT_EN
        ahb_rd(2'd0, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL empty_data got %h want %h", d, 32'd0); miscompares++;
        end
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'h0000_000C) begin
            $display("FAIL underflow_status got %h want %h", d, 32'h0000_000C); miscompares++;
        end
`endif
        ahb_wr(2'd2, 32'd2);
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL clear_flags got %h want %h", d, 32'd0); miscompares++;
        end
        for (int i = 0; i < 3; i++) push(9'(i + 100), 9'(i + 200));
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'h0000_0301) begin
            $display("FAIL three_status got %h want %h", d, 32'h0000_0301); miscompares++;
        end
        ahb_wr(2'd2, 32'd1);
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL flush_status got %h want %h", d, 32'd0); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp;
        push(9'd50, 9'd60);
        push(9'd51, 9'd61);
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'd0;
            @(negedge HCLK);
            HSEL = 1'b0; HTRANS = 2'b00;
            x_in = 9'(52 + k); y_in = 9'(62 + k); DataValid = 1'b1;
            exp = {7'd0, 9'(60 + k), 7'd0, 9'(50 + k)};
            vectors++;
            if (HRDATA !== exp) begin
                $display("FAIL pushpop_%0d got %h want %h", k, HRDATA, exp); miscompares++;
            end
            @(negedge HCLK);
            DataValid = 1'b0;
        end
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'h0000_0201) begin
            $display("FAIL pushpop_status got %h want %h", d, 32'h0000_0201); miscompares++;
        end
        for (int k = 4; k < 6; k++) begin
            exp = {7'd0, 9'(60 + k), 7'd0, 9'(50 + k)};
            ahb_rd(2'd0, d);
            vectors++;
            if (d !== exp) begin
                $display("FAIL wrap_%0d got %h want %h", k, d, exp); miscompares++;
            end
        end
    endtask

`ifdef AHB_IN_WAIT_EN
    task automatic test_wait_stall();
        logic [31:0] d;
        int stall = 0;
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'd0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        for (int i = 0; i < 5; i++) begin
            if (HREADYOUT === 1'b0) stall++;
            if (i == 4) begin
                x_in = 9'h0AB; y_in = 9'h123; DataValid = 1'b1;
            end
            @(negedge HCLK);
        end
        DataValid = 1'b0;
        vectors++;
        if (stall != 5) begin
            $display("FAIL stall_cycles got %0d want 5", stall); miscompares++;
        end
        vectors++;
        if (HREADYOUT !== 1'b1) begin
            $display("FAIL stall_release got %b want 1", HREADYOUT); miscompares++;
        end
        vectors++;
        if (HRDATA !== 32'h0123_00AB) begin
            $display("FAIL stall_data got %h want %h", HRDATA, 32'h0123_00AB); miscompares++;
        end
        ahb_rd(2'd1, d);
        vectors++;
        if (d !== 32'd0) begin
            $display("FAIL stall_status got %h want %h", d, 32'd0); miscompares++;
        end
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'd0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        vectors++;
        if (HREADYOUT !== 1'b0) begin
            $display("FAIL stall_again got %b want 0", HREADYOUT); miscompares++;
        end
        HRESET = 1'b1;
        @(negedge HCLK);
        vectors++;
        if (HREADYOUT !== 1'b1) begin
            $display("FAIL reset_stall got %b want 1", HREADYOUT); miscompares++;
        end
        HRESET = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full_stall();
        test_underflow_ctrl();
        test_back_to_back();
`ifdef AHB_IN_WAIT_EN
        test_wait_stall();
`endif
        repeat (2) @(negedge HCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
